instr_fetch: RTL

//  Instruction-fetch sequencer that feeds the instruction register. On a request from the

---
 rtl/instr_fetch_pkg.sv | 30 +++
 rtl/instr_fetch_timer.sv | 38 +++
 rtl/instr_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Purpose: shared types and defaults for the instruction-fetch sequencer, IR and control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package instr_fetch_pkg;

  // Default instruction word / address geometry.
  localparam int unsigned IW_DEF      = 18;
  localparam int unsigned AW_DEF      = 12;
  localparam int unsigned OP_W        = 6;
  localparam logic [5:0]  HALT_OP_DEF = 6'h3F;
  localparam int unsigned TIMEOUT_DEF = 16;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_LOAD = 3'd2,
    ST_HALT = 3'd3,
    ST_ERR  = 3'd4
  } fetch_state_t;

  // Counter width able to reach TIMEOUT-1; at least one bit so a disabled timer still elaborates.
  function automatic int unsigned timer_width(input int unsigned timeout);
    if (timeout <= 2) begin
      return 1;
    end
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/instr_fetch_timer.sv
// Purpose: loadable up-counter with clear/enable and a terminal-count flag for the fetch timeout.
// Latency: count updates one cycle after clr/ld/en; tc is decoded combinationally from the count.
// Backpressure: none; counts whenever enabled, tc is only meaningful to the caller while waiting.
module fetch_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  output logic          tc
);

  // Terminal value: the last waiting cycle before a timeout is declared.
  localparam logic [CW-1:0] TC_VAL = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Counter register: clear wins over load, load wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // TIMEOUT of zero disables the flag entirely.
  always_comb begin
    tc = (TIMEOUT != 0) && (count == TC_VAL);
  end

endmodule

// File: rtl/instr_fetch.sv
// Purpose: fetch one instruction word at PC over a req/ack handshake and strobe it into the IR.
// Latency: fetch_start at t -> mem_req at t+1; ack at k -> ir_write_en/fetch_done at k+1, idle at k+2.
// Backpressure: holds mem_req/mem_addr until mem_ack; requests outside IDLE are dropped, not queued.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned IW      = IW_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter logic [5:0]  HALT_OP = HALT_OP_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_start,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  output logic          ir_write_en,
  output logic [IW-1:0] ir_data,
  output logic          fetch_done,
  output logic          busy,
  output logic          halted,
  output logic          err,
  output logic [AW-1:0] pc
);

  localparam int unsigned CW = timer_width(TIMEOUT);

  fetch_state_t  state_q;
  fetch_state_t  state_d;

  logic          mem_req_d;
  logic [AW-1:0] mem_addr_d;
  logic          ir_write_en_d;
  logic [IW-1:0] ir_data_d;
  logic          fetch_done_d;
  logic          busy_d;
  logic          halted_d;
  logic          err_d;
  logic [AW-1:0] pc_d;

  logic          tmr_clr;
  logic          tmr_en;
  logic          tmr_tc;
  logic          fetch_accept;
  logic          is_halt_op;

  // A fetch is only accepted while idle; everything else drops the request.
  assign fetch_accept = (state_q == ST_IDLE) && fetch_start;
  assign is_halt_op   = (ir_data[IW-1 -: OP_W] == HALT_OP);

  // The wait counter restarts on every accepted fetch and runs while the request is outstanding.
  assign tmr_clr = fetch_accept;
  assign tmr_en  = (state_q == ST_REQ);

  fetch_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_fetch_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .ld     (1'b0),
    .ld_val ('0),
    .tc     (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HALT and ERR are absorbing until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fetch_start) state_d = ST_REQ;
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_LOAD;
        end else if (tmr_tc) begin
          state_d = ST_ERR;
        end
      end
      ST_LOAD: state_d = is_halt_op ? ST_HALT : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; status flags are decoded from the next state.
  always_comb begin
    pc_d       = pc;
    mem_addr_d = mem_addr;
    ir_data_d  = ir_data;
    case (state_q)
      ST_IDLE: begin
        if (jmp_en) begin
          pc_d = jmp_addr;
        end
        // A jump in the same cycle redirects this very fetch.
        if (fetch_start) begin
          mem_addr_d = jmp_en ? jmp_addr : pc;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          ir_data_d = mem_rdata;
        end
      end
      ST_LOAD: begin
        // Natural AW-bit wrap from all-ones back to zero.
        pc_d = mem_addr + AW'(1);
      end
      default: begin
      end
    endcase
    mem_req_d     = (state_d == ST_REQ);
    ir_write_en_d = (state_d == ST_LOAD);
    fetch_done_d  = (state_d == ST_LOAD);
    busy_d        = (state_d == ST_REQ) || (state_d == ST_LOAD);
    halted_d      = (state_d == ST_HALT);
    err_d         = (state_d == ST_ERR);
  end

  // Output registers; reset aborts any fetch in flight without writing the IR.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      ir_write_en <= 1'b0;
      ir_data     <= '0;
      fetch_done  <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
      pc          <= '0;
    end else begin
      mem_req     <= mem_req_d;
      mem_addr    <= mem_addr_d;
      ir_write_en <= ir_write_en_d;
      ir_data     <= ir_data_d;
      fetch_done  <= fetch_done_d;
      busy        <= busy_d;
      halted      <= halted_d;
      err         <= err_d;
      pc          <= pc_d;
    end
  end

endmodule
